// File: rtl/lms_pkg.sv
// Shared types and helpers for the LMS adaptive filter: FSM states, default widths,
// saturation and accumulator sizing.
package lms_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILT = 2'd1,
        OUT  = 2'd2,
        UPD  = 2'd3
    } state_t;

    localparam int DATA_W        = 8;
    localparam int DEF_COEF_W    = 16;
    localparam int DEF_COEF_FRAC = 12;

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/lms_mac.sv
// Shared signed multiplier with accumulate (x*w) and coefficient-update (w + e*x>>>mu) paths.
// Leaky update is built when LMS_LEAKAGE_EN is defined.
module lms_mac
    import lms_pkg::*;
#(
    parameter int COEF_W     = DEF_COEF_W,
    parameter int ACC_W      = 26,
    parameter int MU_SHIFT   = 4,
    parameter int LEAK_SHIFT = 10
) (
    input  logic                     upd_mode,
    input  logic signed [DATA_W-1:0] x_k,
    input  logic signed [COEF_W-1:0] w_k,
    input  logic signed [DATA_W-1:0] err,
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [ACC_W-1:0]  acc_next,
    output logic signed [COEF_W-1:0] w_next
);

    localparam int PROD_W = DATA_W + COEF_W;

`ifdef LMS_LEAKAGE_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    logic signed [COEF_W-1:0] mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] step;
    logic signed [COEF_W-1:0] leak;
    logic signed [63:0]       w_sum;

    always_comb begin
        // The single multiplier sees the coefficient while filtering and the error while adapting.
        mul_b    = upd_mode ? COEF_W'(err) : w_k;
        prod     = PROD_W'(x_k) * PROD_W'(mul_b);
        step     = prod >>> MU_SHIFT;
        leak     = LEAK_ON ? (w_k >>> LEAK_SHIFT) : '0;
        w_sum    = 64'(w_k) - 64'(leak) + 64'(step);
        w_next   = COEF_W'(sat(w_sum, COEF_W));
        acc_next = acc + ACC_W'(prod);
    end

endmodule

// File: rtl/lms_adapt_filter.sv
// Time-multiplexed LMS FIR: filter TAPS cycles, emit y/e, then adapt TAPS cycles.
// Optional leaky update selected by LMS_LEAKAGE_EN (see lms_mac).
//
// state | meaning
// IDLE  | waiting for sample_valid; shift delay line and latch d on accept
// FILT  | acc += x[k]*w[k], k = 0..TAPS-1
// OUT   | saturate y and e = d - y into the output registers
// UPD   | w[k] update when adapt_en, k = 0..TAPS-1, then back to IDLE
module lms_adapt_filter
    import lms_pkg::*;
#(
    parameter int TAPS       = 16,
    parameter int COEF_W     = DEF_COEF_W,
    parameter int COEF_FRAC  = DEF_COEF_FRAC,
    parameter int MU_SHIFT   = 4,
    parameter int LEAK_SHIFT = 10
) (
    input  logic                     clock_27mhz,
    input  logic                     reset_b,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] d_in,
    input  logic                     adapt_en,
    output logic signed [DATA_W-1:0] y_out,
    output logic signed [DATA_W-1:0] e_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int K_W   = $clog2(TAPS);
    localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

    state_t state, state_nxt;
    logic [K_W-1:0]           k;
    logic signed [DATA_W-1:0] x_dl [TAPS];
    logic signed [COEF_W-1:0] w    [TAPS];
    logic signed [DATA_W-1:0] d_reg;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [COEF_W-1:0] w_next;
    logic signed [DATA_W-1:0] y_sat;
    logic signed [DATA_W-1:0] e_sat;
    logic accept, k_last, acc_en, out_load, upd_step;

    lms_mac #(
        .COEF_W    (COEF_W),
        .ACC_W     (ACC_W),
        .MU_SHIFT  (MU_SHIFT),
        .LEAK_SHIFT(LEAK_SHIFT)
    ) u_mac (
        .upd_mode(upd_step),
        .x_k     (x_dl[k]),
        .w_k     (w[k]),
        .err     (e_out),
        .acc     (acc),
        .acc_next(acc_next),
        .w_next  (w_next)
    );

    assign k_last = (k == K_LAST);

    always_ff @(posedge clock_27mhz or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_valid) state_nxt = FILT;
            FILT:    if (k_last)       state_nxt = OUT;
            OUT:                       state_nxt = UPD;
            UPD:     if (k_last)       state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        accept   = (state == IDLE) && sample_valid;
        acc_en   = (state == FILT);
        out_load = (state == OUT);
        upd_step = (state == UPD);
    end

    always_comb begin
        y_sat = DATA_W'(sat(64'(acc) >>> COEF_FRAC, DATA_W));
        e_sat = DATA_W'(sat(64'(d_reg) - 64'(y_sat), DATA_W));
    end

    always_ff @(posedge clock_27mhz or negedge reset_b) begin
        if (!reset_b) begin
            k         <= '0;
            d_reg     <= '0;
            acc       <= '0;
            y_out     <= '0;
            e_out     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_dl[i] <= '0;
                w[i]    <= '0;
            end
        end else begin
            out_valid <= out_load;
            if (sample_valid && busy) overrun <= 1'b1;
            if (accept) begin
                x_dl[0] <= x_in;
                for (int i = 1; i < TAPS; i++) x_dl[i] <= x_dl[i-1];
                d_reg <= d_in;
                acc   <= '0;
                k     <= '0;
            end
            if (acc_en) begin
                acc <= acc_next;
                k   <= k_last ? '0 : k + 1'b1;
            end
            if (out_load) begin
                y_out <= y_sat;
                e_out <= e_sat;
            end
            // Update cycles are spent even when frozen so the frame timing never changes.
            if (upd_step) begin
                if (adapt_en) w[k] <= w_next;
                k <= k_last ? '0 : k + 1'b1;
            end
        end
    end

endmodule
